// File: rtl/jtag_seq_pkg.sv
// JTAG TAP sequencer shared types: command opcodes, FSM states and TMS navigation patterns.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package jtag_seq_pkg;

  typedef enum logic [1:0] {
    OP_RESET   = 2'd0,
    OP_IDLE    = 2'd1,
    OP_SCAN_IR = 2'd2,
    OP_SCAN_DR = 2'd3
  } op_t;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_HDR,
    ST_SHIFT,
    ST_TRAIL,
    ST_RUN,
    ST_RSP
  } state_t;

  // TMS patterns, LSB is the first value presented to the TAP.
  // Header patterns walk the TAP from Run-Test/Idle into Shift-DR / Shift-IR.
  localparam logic [7:0] HDR_DR_TMS = 8'b0000_0001;  // 1,0,0
  localparam int         HDR_DR_LEN = 3;
  localparam logic [7:0] HDR_IR_TMS = 8'b0000_0011;  // 1,1,0,0
  localparam int         HDR_IR_LEN = 4;
  // Five ones reach Test-Logic-Reset from any state, the trailing zero parks in Run-Test/Idle.
  localparam logic [7:0] RESET_TMS  = 8'b0001_1111;  // 1,1,1,1,1,0
  localparam int         RESET_LEN  = 6;
  // Exit1 -> Update -> Run-Test/Idle after the final shift bit.
  localparam logic [7:0] TRAIL_TMS  = 8'b0000_0001;  // 1,0
  localparam int         TRAIL_LEN  = 2;

  // Index of the last value of the header (or reset) pattern for an op.
  function automatic logic [2:0] hdr_last(input op_t op);
    logic [2:0] last;
    case (op)
      OP_SCAN_DR: last = 3'(HDR_DR_LEN - 1);
      OP_SCAN_IR: last = 3'(HDR_IR_LEN - 1);
      OP_RESET:   last = 3'(RESET_LEN - 1);
      default:    last = 3'd0;
    endcase
    return last;
  endfunction

  // TMS value at position idx of the header (or reset) pattern for an op.
  function automatic logic hdr_tms(input op_t op, input logic [2:0] idx);
    logic [7:0] pat;
    case (op)
      OP_SCAN_DR: pat = HDR_DR_TMS;
      OP_SCAN_IR: pat = HDR_IR_TMS;
      OP_RESET:   pat = RESET_TMS;
      default:    pat = '0;
    endcase
    return pat[idx];
  endfunction

endpackage

// File: rtl/jtag_shift_reg.sv
// Scan data register: parallel load of TDI bits, serial shift towards TDI, TDO captured into the scan window top.
// Latency: one shift per tck while shift is high; ser_out looks one bit ahead during a shift.
// Backpressure: none; contents hold whenever neither load nor shift is asserted.
module jtag_shift_reg #(
  parameter int DR_MAX    = 64,
  parameter int LEN_WIDTH = $clog2(DR_MAX + 1)
) (
  input  logic                 tck,
  input  logic                 trst,
  input  logic                 load,
  input  logic [LEN_WIDTH-1:0] load_len,
  input  logic [DR_MAX-1:0]    load_dat,
  input  logic                 shift,
  input  logic                 ser_in,
  output logic                 ser_out,
  output logic [DR_MAX-1:0]    par_out
);

  logic [DR_MAX-1:0]    q;
  logic [DR_MAX-1:0]    q_nxt;
  logic [DR_MAX-1:0]    shifted;
  logic [LEN_WIDTH-1:0] len_q;

  // Load masks bits above the scan length to zero; a shift moves the window down one place
  // and drops TDO into its top bit, so after len shifts bit i holds the i-th captured bit.
  always_comb begin
    shifted = {1'b0, q[DR_MAX-1:1]};
    q_nxt   = q;
    for (int k = 0; k < DR_MAX; k++) begin
      if (load) begin
        q_nxt[k] = (k < int'(load_len)) ? load_dat[k] : 1'b0;
      end else if (shift) begin
        if (k == int'(len_q) - 1) begin
          q_nxt[k] = ser_in;
        end else if (k < int'(len_q) - 1) begin
          q_nxt[k] = shifted[k];
        end
      end
    end
  end

  // Register contents and the latched scan length.
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      q     <= '0;
      len_q <= '0;
    end else begin
      q <= q_nxt;
      if (load) begin
        len_q <= load_len;
      end
    end
  end

  // While shifting, the bit that becomes the LSB after this edge is q[1].
  assign ser_out = shift ? q[1] : q[0];
  assign par_out = q;

endmodule

// File: rtl/jtag_tap_sequencer.sv
// Turns reset/idle/IR-scan/DR-scan commands into registered TMS/TDI sequences and returns captured TDO bits.
// Latency: response at E(L+5) for DR scans, E(L+6) for IR scans, E6 for reset, E(max(N,1)) for idle.
// Backpressure: one command in flight; cmd_ready only in IDLE, response held until rsp_ready.
module jtag_tap_sequencer
  import jtag_seq_pkg::*;
#(
  parameter int INSN_WIDTH = 8,
  parameter int DR_MAX     = 64,
  parameter int LEN_WIDTH  = $clog2(DR_MAX + 1)
) (
  input  logic                 tck,
  input  logic                 trst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [LEN_WIDTH-1:0] cmd_len,
  input  logic [DR_MAX-1:0]    cmd_data,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DR_MAX-1:0]    rsp_data,
  output logic                 tap_tms,
  output logic                 tap_tdi,
  input  logic                 tap_tdo,
  output logic                 busy
);

  // IR scans share the DR_MAX-wide data path, so the nominal IR must fit in it.
  if (INSN_WIDTH < 1 || INSN_WIDTH > DR_MAX) begin : g_bad_insn_width
    $error("INSN_WIDTH must be between 1 and DR_MAX");
  end

  state_t               state_q, state_nxt;
  op_t                  op_q, op_nxt;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_nxt;
  logic [LEN_WIDTH-1:0] len_q, len_nxt;
  logic [LEN_WIDTH-1:0] scan_len;
  logic [LEN_WIDTH-1:0] run_len;
  logic                 accept;
  logic                 is_scan;
  logic                 tms_nxt;
  logic                 tdi_nxt;
  logic                 sr_ser;

  assign accept  = cmd_valid && (state_q == ST_IDLE);
  assign is_scan = (op_t'(cmd_op) == OP_SCAN_IR) || (op_t'(cmd_op) == OP_SCAN_DR);

  // Scan length: 0 means 1, anything above DR_MAX saturates. Idle count: 0 means 1.
  always_comb begin
    if (cmd_len == '0) begin
      scan_len = LEN_WIDTH'(1);
    end else if (cmd_len > LEN_WIDTH'(DR_MAX)) begin
      scan_len = LEN_WIDTH'(DR_MAX);
    end else begin
      scan_len = cmd_len;
    end
    run_len = (cmd_len == '0) ? LEN_WIDTH'(1) : cmd_len;
  end

  // FSM state, pattern counter, latched op and length.
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      state_q <= ST_INIT;
      op_q    <= OP_RESET;
      cnt_q   <= '0;
      len_q   <= LEN_WIDTH'(1);
    end else begin
      state_q <= state_nxt;
      op_q    <= op_nxt;
      cnt_q   <= cnt_nxt;
      len_q   <= len_nxt;
    end
  end

  // Next state: each state counts through its pattern, then hands over.
  always_comb begin
    state_nxt = state_q;
    op_nxt    = op_q;
    cnt_nxt   = cnt_q + LEN_WIDTH'(1);
    len_nxt   = len_q;
    case (state_q)
      ST_INIT: begin
        if (cnt_q == LEN_WIDTH'(hdr_last(OP_RESET))) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      end
      ST_IDLE: begin
        cnt_nxt = '0;
        if (cmd_valid) begin
          op_nxt    = op_t'(cmd_op);
          state_nxt = (op_t'(cmd_op) == OP_IDLE) ? ST_RUN : ST_HDR;
          len_nxt   = (op_t'(cmd_op) == OP_IDLE) ? run_len : scan_len;
        end
      end
      ST_HDR: begin
        if (cnt_q == LEN_WIDTH'(hdr_last(op_q))) begin
          state_nxt = (op_q == OP_RESET) ? ST_RSP : ST_SHIFT;
          cnt_nxt   = '0;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == len_q - LEN_WIDTH'(1)) begin
          state_nxt = ST_TRAIL;
          cnt_nxt   = '0;
        end
      end
      ST_TRAIL: begin
        if (cnt_q == LEN_WIDTH'(TRAIL_LEN - 1)) begin
          state_nxt = ST_RSP;
          cnt_nxt   = '0;
        end
      end
      ST_RUN: begin
        if (cnt_q == len_q - LEN_WIDTH'(1)) begin
          state_nxt = ST_RSP;
          cnt_nxt   = '0;
        end
      end
      ST_RSP: begin
        cnt_nxt = '0;
        if (rsp_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_INIT;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs: handshakes from the current state; pin values decoded from the next state so they can be registered.
  always_comb begin
    cmd_ready = (state_q == ST_IDLE);
    rsp_valid = (state_q == ST_RSP);
    busy      = (state_q != ST_IDLE);
    tdi_nxt   = 1'b0;
    case (state_nxt)
      ST_INIT:  tms_nxt = hdr_tms(OP_RESET, cnt_nxt[2:0]);
      ST_HDR:   tms_nxt = hdr_tms(op_nxt, cnt_nxt[2:0]);
      ST_SHIFT: begin
        tms_nxt = (cnt_nxt == len_nxt - LEN_WIDTH'(1));
        tdi_nxt = sr_ser;
      end
      ST_TRAIL: tms_nxt = TRAIL_TMS[cnt_nxt[2:0]];
      default:  tms_nxt = 1'b0;
    endcase
  end

  // Registered TAP pins; reset holds TMS high so the TAP falls into Test-Logic-Reset.
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      tap_tms <= 1'b1;
      tap_tdi <= 1'b0;
    end else begin
      tap_tms <= tms_nxt;
      tap_tdi <= tdi_nxt;
    end
  end

  jtag_shift_reg #(
    .DR_MAX    (DR_MAX),
    .LEN_WIDTH (LEN_WIDTH)
  ) u_shift_reg (
    .tck      (tck),
    .trst     (trst),
    .load     (accept),
    .load_len (scan_len),
    .load_dat (is_scan ? cmd_data : '0),
    .shift    (state_q == ST_SHIFT),
    .ser_in   (tap_tdo),
    .ser_out  (sr_ser),
    .par_out  (rsp_data)
  );

endmodule

// File: tb/tb_jtag_tap_sequencer.sv
// Directed bench for jtag_tap_sequencer driving a behavioural single-TAP model (8-bit IR, IDCODE, BYPASS).
// Latency: responses checked at their exact edge index after acceptance.
// Backpressure: rsp_ready is held off to verify the response holds.
module tb_jtag_tap_sequencer;

  localparam int DR_MAX     = 64;
  localparam int LW         = $clog2(DR_MAX + 1);
  localparam int INSN_WIDTH = 8;

  localparam logic [7:0]  IDCODE_INSN = 8'h02;
  localparam logic [7:0]  BYPASS_INSN = 8'hFF;
  localparam logic [31:0] IDCODE_VAL  = 32'h1DC0DE01;

  localparam logic [1:0] C_RESET = 2'd0, C_IDLE = 2'd1, C_IR = 2'd2, C_DR = 2'd3;

  logic              tck = 1'b0;
  logic              trst = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [1:0]        cmd_op = '0;
  logic [LW-1:0]     cmd_len = '0;
  logic [DR_MAX-1:0] cmd_data = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DR_MAX-1:0] rsp_data;
  logic              tap_tms;
  logic              tap_tdi;
  logic              tap_tdo = 1'b0;
  logic              busy;

  int total = 0;
  int bad   = 0;

  always #5 tck = ~tck;

  jtag_tap_sequencer #(
    .INSN_WIDTH (INSN_WIDTH),
    .DR_MAX     (DR_MAX),
    .LEN_WIDTH  (LW)
  ) dut (
    .tck       (tck),
    .trst      (trst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .tap_tms   (tap_tms),
    .tap_tdi   (tap_tdi),
    .tap_tdo   (tap_tdo),
    .busy      (busy)
  );

  // ---------------- behavioural TAP ----------------
  typedef enum logic [3:0] {
    TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PADR, EX2DR, UPDR,
    SELIR, CAPIR, SHIR, EX1IR, PAIR, EX2IR, UPIR
  } tap_t;

  tap_t        ts = TLR;
  logic [7:0]  ir = IDCODE_INSN;
  logic [7:0]  ir_sr = '0;
  logic [63:0] dr_sr = '0;
  int          dr_len = 1;

  function automatic tap_t tap_next(input tap_t s, input logic tms);
    case (s)
      TLR:     return tms ? TLR   : RTI;
      RTI:     return tms ? SELDR : RTI;
      SELDR:   return tms ? SELIR : CAPDR;
      CAPDR:   return tms ? EX1DR : SHDR;
      SHDR:    return tms ? EX1DR : SHDR;
      EX1DR:   return tms ? UPDR  : PADR;
      PADR:    return tms ? EX2DR : PADR;
      EX2DR:   return tms ? UPDR  : SHDR;
      UPDR:    return tms ? SELDR : RTI;
      SELIR:   return tms ? TLR   : CAPIR;
      CAPIR:   return tms ? EX1IR : SHIR;
      SHIR:    return tms ? EX1IR : SHIR;
      EX1IR:   return tms ? UPIR  : PAIR;
      PAIR:    return tms ? EX2IR : PAIR;
      EX2IR:   return tms ? UPIR  : SHIR;
      default: return tms ? SELDR : RTI;
    endcase
  endfunction

  always @(posedge tck) begin
    case (ts)
      TLR:   ir = IDCODE_INSN;
      CAPDR: begin
        if (ir == IDCODE_INSN) begin
          dr_sr = {32'h0, IDCODE_VAL};
          dr_len = 32;
        end else begin
          dr_sr = '0;
          dr_len = 1;
        end
      end
      SHDR: begin
        dr_sr = dr_sr >> 1;
        dr_sr[dr_len-1] = tap_tdi;
      end
      CAPIR: ir_sr = 8'h01;
      SHIR:  ir_sr = {tap_tdi, ir_sr[7:1]};
      UPIR:  ir = ir_sr;
      default: ;
    endcase
    ts = tap_next(ts, tap_tms);
  end

  // TDO changes on the falling edge, as a real TAP does.
  always @(negedge tck) begin
    tap_tdo = (ts == SHDR) ? dr_sr[0] : ((ts == SHIR) ? ir_sr[0] : 1'b0);
  end

  // ---------------- stimulus helpers ----------------
  // Issue one command from IDLE; n = edge index at which rsp_valid is first seen,
  // tl[k] = TMS value sampled by the TAP at edge k+1.
  task automatic run_cmd(input logic [1:0] op, input logic [LW-1:0] len, input logic [63:0] data,
                         output int n, output logic [255:0] tl);
    tl = '0;
    n = 0;
    cmd_op = op;
    cmd_len = len;
    cmd_data = data;
    cmd_valid = 1'b1;
    @(posedge tck); #1;
    cmd_valid = 1'b0;
    cmd_data = ~data;
    cmd_len = 7'h55;
    cmd_op = ~op;
    while (n < 200 && !rsp_valid) begin
      tl[n] = tap_tms;
      @(posedge tck); #1;
      n++;
    end
  endtask

  task automatic ack_rsp();
    rsp_ready = 1'b1;
    @(posedge tck); #1;
    rsp_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_init(input string tag);
    logic [5:0] exp;
    exp = 6'b011111;
    for (int k = 0; k < 6; k++) begin
      total++; if (tap_tms !== exp[k] || cmd_ready !== 1'b0) begin
        $display("FAIL %s init step %0d: tms=%b cmd_ready=%b, want tms=%b cmd_ready=0", tag, k, tap_tms, cmd_ready, exp[k]); bad++; end
      @(posedge tck); #1;
    end
    total++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL %s ready after init: cmd_ready=%b busy=%b, want 1/0", tag, cmd_ready, busy); bad++; end
    total++; if (ts !== RTI) begin
      $display("FAIL %s tap state after init: %0d, want %0d", tag, ts, RTI); bad++; end
  endtask

  task automatic test_reset();
    trst = 1'b0;
    repeat (3) @(posedge tck);
    #1;
    total++; if (tap_tms !== 1'b1 || tap_tdi !== 1'b0) begin
      $display("FAIL reset pins: tms=%b tdi=%b, want 1/0", tap_tms, tap_tdi); bad++; end
    total++; if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL reset handshakes: cmd_ready=%b rsp_valid=%b busy=%b, want 0/0/1", cmd_ready, rsp_valid, busy); bad++; end
    total++; if (rsp_data !== 64'h0) begin
      $display("FAIL reset rsp_data: %h, want 0", rsp_data); bad++; end
    trst = 1'b1;
    test_init("reset");
  endtask

  task automatic test_ir_scan();
    int n; logic [255:0] tl;
    run_cmd(C_IR, 7'd8, 64'h02, n, tl);
    total++; if (n !== 14) begin $display("FAIL ir latency: E%0d, want E14", n); bad++; end
    total++; if (tl[13:0] !== 14'h1803) begin $display("FAIL ir tms: %h, want 1803", tl[13:0]); bad++; end
    total++; if (rsp_data !== 64'h01) begin $display("FAIL ir capture: %h, want 01", rsp_data); bad++; end
    ack_rsp();
    total++; if (cmd_ready !== 1'b1) begin $display("FAIL ir ready after ack: %b, want 1", cmd_ready); bad++; end
    total++; if (ir !== IDCODE_INSN || ts !== RTI) begin
      $display("FAIL ir model: ir=%h state=%0d, want %h/%0d", ir, ts, IDCODE_INSN, RTI); bad++; end
  endtask

  task automatic test_idcode(input string tag);
    int n; logic [255:0] tl;
    run_cmd(C_DR, 7'd32, 64'hFFFF_0000_CAFE_F00D, n, tl);
    total++; if (n !== 37) begin $display("FAIL %s dr latency: E%0d, want E37", tag, n); bad++; end
    total++; if (tl[36:0] !== 37'h0C00000001) begin $display("FAIL %s dr tms: %h, want 0c00000001", tag, tl[36:0]); bad++; end
    total++; if (rsp_data !== 64'h0000_0000_1DC0_DE01) begin
      $display("FAIL %s idcode: %h, want 000000001dc0de01", tag, rsp_data); bad++; end
    ack_rsp();
  endtask

  task automatic test_bypass();
    int n; logic [255:0] tl;
    run_cmd(C_IR, 7'd8, {56'h0, BYPASS_INSN}, n, tl);
    total++; if (n !== 14 || ir !== BYPASS_INSN) begin
      $display("FAIL bypass ir load: E%0d ir=%h, want E14 ff", n, ir); bad++; end
    ack_rsp();
    run_cmd(C_DR, 7'd9, 64'h1AB, n, tl);
    total++; if (n !== 14) begin $display("FAIL bypass latency: E%0d, want E14", n); bad++; end
    total++; if (rsp_data !== 64'h156) begin $display("FAIL bypass data: %h, want 156", rsp_data); bad++; end
    ack_rsp();
  endtask

  task automatic test_backpressure();
    int n; logic [255:0] tl;
    run_cmd(C_DR, 7'd9, 64'h0F0, n, tl);
    total++; if (n !== 14) begin $display("FAIL bp latency: E%0d, want E14", n); bad++; end
    for (int c = 0; c < 10; c++) begin
      total++; if (rsp_valid !== 1'b1 || rsp_data !== 64'h1E0 || cmd_ready !== 1'b0 || tap_tms !== 1'b0) begin
        $display("FAIL bp hold cycle %0d: vld=%b dat=%h rdy=%b tms=%b, want 1/1e0/0/0", c, rsp_valid, rsp_data, cmd_ready, tap_tms); bad++; end
      @(posedge tck); #1;
    end
    ack_rsp();
    total++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      $display("FAIL bp release: vld=%b rdy=%b, want 0/1", rsp_valid, cmd_ready); bad++; end
  endtask

  task automatic test_reset_cmd();
    int n; logic [255:0] tl;
    run_cmd(C_RESET, 7'd0, 64'hDEAD_BEEF, n, tl);
    total++; if (n !== 6) begin $display("FAIL rstcmd latency: E%0d, want E6", n); bad++; end
    total++; if (tl[5:0] !== 6'b011111) begin $display("FAIL rstcmd tms: %b, want 011111", tl[5:0]); bad++; end
    total++; if (rsp_data !== 64'h0) begin $display("FAIL rstcmd data: %h, want 0", rsp_data); bad++; end
    total++; if (ir !== IDCODE_INSN || ts !== RTI) begin
      $display("FAIL rstcmd model: ir=%h state=%0d, want %h/%0d", ir, ts, IDCODE_INSN, RTI); bad++; end
    ack_rsp();
  endtask

  task automatic test_clamp();
    int n; logic [255:0] tl;
    run_cmd(C_DR, 7'd0, 64'h1, n, tl);
    total++; if (n !== 6) begin $display("FAIL len0 latency: E%0d, want E6", n); bad++; end
    total++; if (tl[5:0] !== 6'b011001) begin $display("FAIL len0 tms: %b, want 011001", tl[5:0]); bad++; end
    total++; if (rsp_data !== 64'h1) begin $display("FAIL len0 data: %h, want 1", rsp_data); bad++; end
    ack_rsp();
    run_cmd(C_DR, 7'd127, 64'hA5A5_5A5A_1234_5678, n, tl);
    total++; if (n !== 69) begin $display("FAIL len127 latency: E%0d, want E69", n); bad++; end
    total++; if (rsp_data !== 64'h1234_5678_1DC0_DE01) begin
      $display("FAIL len127 data: %h, want 123456781dc0de01", rsp_data); bad++; end
    ack_rsp();
  endtask

  task automatic test_idle_cmd();
    int n; logic [255:0] tl;
    run_cmd(C_IDLE, 7'd5, 64'h77, n, tl);
    total++; if (n !== 5 || tl[4:0] !== 5'b0) begin $display("FAIL idle5: E%0d tms=%b, want E5 00000", n, tl[4:0]); bad++; end
    total++; if (rsp_data !== 64'h0 || ts !== RTI) begin
      $display("FAIL idle5 data/state: %h/%0d, want 0/%0d", rsp_data, ts, RTI); bad++; end
    ack_rsp();
    run_cmd(C_IDLE, 7'd0, 64'h0, n, tl);
    total++; if (n !== 1) begin $display("FAIL idle0 latency: E%0d, want E1", n); bad++; end
    ack_rsp();
  endtask

  task automatic test_reset_midscan();
    cmd_op = C_DR;
    cmd_len = 7'd64;
    cmd_data = '1;
    cmd_valid = 1'b1;
    @(posedge tck); #1;
    cmd_valid = 1'b0;
    repeat (23) @(posedge tck);
    #1;
    total++; if (tap_tdi !== 1'b1 || tap_tms !== 1'b0 || ts !== SHDR) begin
      $display("FAIL midscan bit20: tdi=%b tms=%b state=%0d, want 1/0/%0d", tap_tdi, tap_tms, ts, SHDR); bad++; end
    trst = 1'b0;
    #1;
    total++; if (tap_tms !== 1'b1 || tap_tdi !== 1'b0 || cmd_ready !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b1 || rsp_data !== 64'h0) begin
      $display("FAIL midscan reset outs: tms=%b tdi=%b rdy=%b vld=%b busy=%b dat=%h, want 1/0/0/0/1/0",
               tap_tms, tap_tdi, cmd_ready, rsp_valid, busy, rsp_data); bad++; end
    for (int c = 0; c < 3; c++) begin
      @(posedge tck); #1;
      total++; if (rsp_valid !== 1'b0) begin $display("FAIL midscan rsp during reset: %b, want 0", rsp_valid); bad++; end
    end
    trst = 1'b1;
    test_init("midscan");
    test_idcode("after_midscan");
  endtask

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time bound, bad=%0d", bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ir_scan();
    test_idcode("idcode");
    test_bypass();
    test_backpressure();
    test_reset_cmd();
    test_clamp();
    test_idle_cmd();
    test_reset_midscan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jtag_tap_sequencer.md
# jtag_tap_sequencer

Host-side command sequencer that drives the TMS/TDI pins of a downstream JTAG TAP chain from a simple command stream and returns the TDO bits it captures. It hides TAP state-machine navigation: each command (reset, idle, IR scan, DR scan) becomes the correct TMS/TDI bit sequence, and the block tracks the TAP state as a mirror. It runs in the tck domain and connects directly to the TAP pins. A debug-access or host bridge sits upstream and issues commands.

## Interface
- INSN_WIDTH, 8: nominal IR length; informational, used by the bench.
- DR_MAX, 64: maximum scan length in bits; sets the data width.
- LEN_WIDTH, $clog2(DR_MAX+1): width of the length field.

- tck  in  1  clock. One clock; all state changes on the rising edge.
- trst  in  1  reset. Asynchronous, active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when both are high at a rising edge.
- cmd_op  in  2  operation: 0 RESET, 1 IDLE, 2 SCAN_IR, 3 SCAN_DR.
- cmd_len  in  LEN_WIDTH  scan bit count, or idle cycle count.
- cmd_data  in  DR_MAX  TDI bits, shifted LSB first.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  result consumed.
- rsp_data  out  DR_MAX  captured TDO bits; bit i is the i-th bit shifted out; unused bits are 0.
- tap_tms  out  1  registered TMS to the TAP.
- tap_tdi  out  1  registered TDI to the TAP.
- tap_tdo  in  1  TDO from the TAP, sampled on the rising edge.
- busy  out  1  high whenever the FSM is not in IDLE.

## Operation
- **FSM states:** INIT, IDLE, HDR, SHIFT, TRAIL, RUN, RSP.
- **INIT:** entered on trst release.
  - Drives the TMS pattern 1,1,1,1,1,0, forcing the TAP to Test-Logic-Reset and then Run-Test/Idle.
  - Goes to IDLE. No response is produced.
- **IDLE:**
  - tap_tms=0, tap_tdi=0.
  - cmd_ready=1 only in IDLE. It is 0 while rsp_valid=1.
- **Emitted pattern per command.** Each value is presented for one tck:
  - SCAN_DR: HDR 1,0,0; SHIFT L values with TMS=0 except the last, which is TMS=1; TRAIL 1,0. Total L+5 values.
  - SCAN_IR: HDR 1,1,0,0; SHIFT as above; TRAIL 1,0. Total L+6 values.
  - RESET: 1,1,1,1,1,0. Total 6 values. rsp_data=0.
  - IDLE: max(N,1) values of 0 (RUN state). rsp_data=0.
- **SHIFT data path:**
  - tap_tdi = cmd_data[i] for shift bit i.
  - tap_tdo is captured into rsp_data[i] at the edge where the TAP consumes bit i.
- **Length rules:**
  - Scan L=0 is treated as L=1.
  - L>DR_MAX is clamped to DR_MAX.
  - Clamping applies identically to IR and DR scans, so multi-TAP chains are supported.
- **Outside SHIFT:** tap_tdi=0.
- **RSP:**
  - rsp_valid=1 and rsp_data are held stable until rsp_ready=1.
  - Then the FSM returns to IDLE; cmd_ready rises the following cycle.
- **Async reset (trst=0), any time including mid-scan:**
  - tap_tms=1, tap_tdi=0, cmd_ready=0, rsp_valid=0, rsp_data=0, busy=1.
  - Any in-flight command and pending response are discarded.
  - On release the FSM restarts in INIT.

## Timing
- **Numbering:** E0 is the acceptance edge. The value presented after edge Ek is sampled by the TAP at Ek+1.
- **SCAN_DR:**
  - TAP enters Shift-DR at E3.
  - tdi bit i is sampled at E(4+i); tdo bit i is captured at E(4+i).
  - rsp_valid is set at E(L+5).
- **SCAN_IR:**
  - Same as SCAN_DR, offset by one: Shift-IR is entered at E4.
  - rsp_valid is set at E(L+6).
- **RESET:** rsp_valid is set at E6.
- **IDLE(N):** rsp_valid is set at E(max(N,1)).
- **After INIT:** cmd_ready is set at the 6th edge after trst release.
- **Throughput:** one command in flight. Minimum gap between commands is 1 cycle after the rsp handshake.
- **Handshakes:** both are standard valid/ready. Inputs are sampled only at the acceptance edge. cmd_data is latched; later changes are ignored.

## Structure
- **Package jtag_seq_pkg:**
  - op enum (RESET/IDLE/SCAN_IR/SCAN_DR).
  - FSM state enum.
  - HDR/TRAIL/RESET TMS pattern constants and their lengths.
- **Sub-module jtag_shift_reg:**
  - DR_MAX-bit shift register.
  - Parallel load from cmd_data.
  - Serial out LSB to tap_tdi; serial in tap_tdo at bit index i.
  - Parallel out to rsp_data.
- **Top level:** FSM plus the bit/pattern counter (LEN_WIDTH bits).

## Test plan
- **Reset/INIT:** trst pulse low → tap_tms=1 during reset; after release, TMS 1,1,1,1,1,0 over 6 edges; cmd_ready=1 from the 6th edge; bench TAP model is in Run-Test/Idle.
- **IR scan:** SCAN_IR L=8, data 0x02 → TMS 1,1,0,0,0×7,1,1,0; rsp_valid at E14; rsp_data[1:0]=2'b01 (IR capture pattern).
- **DR scan of IDCODE:** SCAN_DR L=32 after the IDCODE IR → rsp_data = model IDCODE 0x1DC0DE01 at E37; rsp_data[63:32]=0.
- **BYPASS:** IR=0xFF, then SCAN_DR L=9, data 0x1AB → rsp_data=0x156 (data shifted by the 1-bit bypass register, bit0=0).
- **Backpressure and clamping:**
  - rsp_ready held low 10 cycles → rsp_valid and rsp_data stable, cmd_ready=0, tap_tms=0.
  - SCAN_DR L=0 behaves as L=1; L=127 behaves as L=64.
- **Reset mid-scan:** trst low during bit 20 of a 64-bit SCAN_DR → outputs immediately take reset values; no rsp_valid; after release, INIT repeats and a following IDCODE scan is correct.
